// File: rtl/svc_rv_perf_pkg.sv
// svc_rv_perf_pkg: shared state encoding and sizing helpers for the perf/CPI unit
package svc_rv_perf_pkg;
  typedef enum logic [1:0] {PERF_IDLE, PERF_DIV, PERF_DONE} perf_state_t;
  function automatic int perf_div_iters(input int cnt_w, input int frac_bits);
    return cnt_w + frac_bits;
  endfunction
endpackage

// File: rtl/svc_rv_perf_div.sv
// svc_rv_perf_div: iterative restoring divider, one quotient bit per cycle
module svc_rv_perf_div #(
  parameter int DVD_W = 40,
  parameter int DVS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);
  localparam int CW = $clog2(DVD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DVD_W - 1);
  logic [DVS_W-1:0] rem, dvs;
  logic [CW-1:0] cnt;
  logic [DVS_W+DVD_W-1:0] nxt_run, nxt_start;
  // quotient bits shift in where dividend bits shift out
  function automatic logic [DVS_W+DVD_W-1:0] step(input logic [DVS_W-1:0] r, input logic [DVD_W-1:0] q,
                                                 input logic [DVS_W-1:0] d);
    logic [DVS_W:0] s, t;
    s = {r, q[DVD_W-1]};
    t = s - {1'b0, d};
    return (s >= {1'b0, d}) ? {t[DVS_W-1:0], q[DVD_W-2:0], 1'b1} : {s[DVS_W-1:0], q[DVD_W-2:0], 1'b0};
  endfunction
  assign nxt_run = step(rem, quotient, dvs);
  assign nxt_start = step('0, dividend, divisor);
  // the start edge already performs the first iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem <= '0;
      dvs <= '0;
      quotient <= '0;
      cnt <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem <= '0;
      dvs <= '0;
      quotient <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (!busy && start) begin
        {rem, quotient} <= nxt_start;
        dvs <= divisor;
        cnt <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        {rem, quotient} <= nxt_run;
        cnt <= cnt + 1'b1;
        busy <= cnt != LAST;
        done <= cnt == LAST;
      end
    end
  end
endmodule

// File: rtl/svc_rv_perf_cpi.sv
// svc_rv_perf_cpi: saturating cycle/instret/event counters with fixed-point CPI on halt
module svc_rv_perf_cpi
  import svc_rv_perf_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int NUM_EVENTS = 4,
  parameter int FRAC_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clear,
  input  logic                        retire,
  input  logic [NUM_EVENTS-1:0]       event_i,
  input  logic                        halt,
  output logic [CNT_W-1:0]            cycles,
  output logic [CNT_W-1:0]            instrs,
  output logic [NUM_EVENTS*CNT_W-1:0] events,
  output logic [NUM_EVENTS+1:0]       ovf,
  output logic [CNT_W-1:0]            cpi_q,
  output logic                        cpi_busy,
  output logic                        cpi_valid,
  output logic                        cpi_div0,
  output logic                        cpi_sat
);
  localparam int NC = NUM_EVENTS + 2;
  localparam int N = perf_div_iters(CNT_W, FRAC_BITS);
  logic [CNT_W-1:0] cnt [NC];
  logic [NC-1:0] inc;
  logic halt_q, rise, div_start, div_busy, div_done, quo_hi;
  logic [N-1:0] quo;
  perf_state_t state;
  assign inc = {NC{en & ~halt}} & {event_i, retire, 1'b1};
  assign rise = halt & ~halt_q;
  assign div_start = rise && !clear && !div_busy && state != PERF_DIV && cnt[1] != '0;
  assign quo_hi = |quo[N-1 -: FRAC_BITS];
  assign cycles = cnt[0];
  assign instrs = cnt[1];
  assign cpi_busy = state == PERF_DIV;
  assign cpi_valid = state == PERF_DONE;
  always_comb begin
    events = '0;
    for (int k = 0; k < NUM_EVENTS; k++) events[k*CNT_W +: CNT_W] = cnt[k+2];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clear) begin
      for (int i = 0; i < NC; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NC; i++)
        if (inc[i]) begin
          if (&cnt[i]) ovf[i] <= 1'b1;
          else cnt[i] <= cnt[i] + 1'b1;
        end
    end
  end
  // halt_q resets high so a halt held across reset needs a fresh rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PERF_IDLE;
      halt_q <= 1'b1;
      cpi_q <= '0;
      cpi_div0 <= 1'b0;
      cpi_sat <= 1'b0;
    end else begin
      halt_q <= halt;
      if (clear) begin
        state <= PERF_IDLE;
        cpi_q <= '0;
        cpi_div0 <= 1'b0;
        cpi_sat <= 1'b0;
      end else if (state == PERF_DIV) begin
        if (div_done) begin
          state <= PERF_DONE;
          cpi_sat <= quo_hi;
          cpi_q <= quo_hi ? '1 : quo[CNT_W-1:0];
        end
      end else if (rise) begin
        cpi_sat <= 1'b0;
        cpi_div0 <= cnt[1] == '0;
        cpi_q <= cnt[1] == '0 ? '1 : cpi_q;
        state <= cnt[1] == '0 ? PERF_DONE : PERF_DIV;
      end
    end
  end
  svc_rv_perf_div #(.DVD_W(N), .DVS_W(CNT_W)) u_div (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .start(div_start),
    .dividend({cnt[0], {FRAC_BITS{1'b0}}}),
    .divisor(cnt[1]),
    .busy(div_busy),
    .done(div_done),
    .quotient(quo)
  );
endmodule

// File: tb/tb_svc_rv_perf_cpi.sv
// tb_svc_rv_perf_cpi: scoreboard bench driving a 32-bit and an 8-bit instance in lockstep
module tb_svc_rv_perf_cpi;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clear = 1'b0, retire = 1'b0, halt = 1'b0;
  logic [3:0] ev = '0;
  logic [31:0] cyc_a, ins_a, q_a;
  logic [127:0] evs_a;
  logic [5:0] ovf_a, ovf_b;
  logic [7:0] cyc_b, ins_b, q_b;
  logic [31:0] evs_b;
  logic busy_a, valid_a, div0_a, sat_a, busy_b, valid_b, div0_b, sat_b;
  logic [31:0] q_o [2];
  logic busy_o [2], valid_o [2], div0_o [2], sat_o [2];
  typedef struct {longint q; bit div0; bit sat; int busy;} exp_t;
  exp_t sbq [2][$];
  exp_t ex;
  int n_chk = 0, n_fail = 0;
  longint m_cyc, m_ins, m_ev [4];
  bit m_hprev;
  int m_busy [2];
  int wid [2] = '{32, 8};
  int frb [2] = '{8, 4};
  int bcnt [2];
  logic pv [2];
  logic [31:0] pq [2];

  always #5 clk = ~clk;

  svc_rv_perf_cpi #(.CNT_W(32), .NUM_EVENTS(4), .FRAC_BITS(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .retire(retire), .event_i(ev), .halt(halt),
    .cycles(cyc_a), .instrs(ins_a), .events(evs_a), .ovf(ovf_a), .cpi_q(q_a),
    .cpi_busy(busy_a), .cpi_valid(valid_a), .cpi_div0(div0_a), .cpi_sat(sat_a));
  svc_rv_perf_cpi #(.CNT_W(8), .NUM_EVENTS(4), .FRAC_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .retire(retire), .event_i(ev), .halt(halt),
    .cycles(cyc_b), .instrs(ins_b), .events(evs_b), .ovf(ovf_b), .cpi_q(q_b),
    .cpi_busy(busy_b), .cpi_valid(valid_b), .cpi_div0(div0_b), .cpi_sat(sat_b));

  assign q_o[0] = q_a;
  assign q_o[1] = {24'b0, q_b};
  assign busy_o[0] = busy_a;
  assign busy_o[1] = busy_b;
  assign valid_o[0] = valid_a;
  assign valid_o[1] = valid_b;
  assign div0_o[0] = div0_a;
  assign div0_o[1] = div0_b;
  assign sat_o[0] = sat_a;
  assign sat_o[1] = sat_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint wmax(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint satw(input longint v, input int w);
    return v > wmax(w) ? wmax(w) : v;
  endfunction

  function automatic logic [5:0] exp_ovf(input int w);
    logic [5:0] o;
    o[0] = m_cyc > wmax(w);
    o[1] = m_ins > wmax(w);
    for (int k = 0; k < 4; k++) o[2+k] = m_ev[k] > wmax(w);
    return o;
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    m_ins = 0;
    for (int k = 0; k < 4; k++) m_ev[k] = 0;
    m_hprev = 1'b1;
    m_busy = '{0, 0};
    sbq[0].delete();
    sbq[1].delete();
  endtask

  // behavioural reference: raw unbounded counts, saturation applied only when observed
  task automatic model_edge(input bit e, input bit c, input bit r, input logic [3:0] x, input bit h);
    exp_t t;
    longint sc, si, quo;
    if (c) begin
      model_reset();
      m_hprev = h;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d] > 0) m_busy[d]--;
      else if (h && !m_hprev) begin
        sc = satw(m_cyc, wid[d]);
        si = satw(m_ins, wid[d]);
        if (si == 0) begin
          t.q = wmax(wid[d]); t.div0 = 1; t.sat = 0; t.busy = 0;
        end else begin
          quo = (sc << frb[d]) / si;
          t.div0 = 0;
          t.sat = quo > wmax(wid[d]);
          t.q = t.sat ? wmax(wid[d]) : quo;
          t.busy = wid[d] + frb[d];
        end
        sbq[d].push_back(t);
        m_busy[d] = t.busy;
      end
    end
    if (e && !h) begin
      m_cyc++;
      if (r) m_ins++;
      for (int k = 0; k < 4; k++) if (x[k]) m_ev[k]++;
    end
    m_hprev = h;
  endtask

  task automatic step(input bit e, input bit c, input bit r, input logic [3:0] x, input bit h);
    en = e; clear = c; retire = r; ev = x; halt = h;
    @(posedge clk);
    model_edge(e, c, r, x, h);
    #1;
  endtask

  task automatic check_counts();
    chk("cycles32", cyc_a, satw(m_cyc, 32));
    chk("instrs32", ins_a, satw(m_ins, 32));
    chk("ovf32", ovf_a, exp_ovf(32));
    chk("cycles8", cyc_b, satw(m_cyc, 8));
    chk("instrs8", ins_b, satw(m_ins, 8));
    chk("ovf8", ovf_b, exp_ovf(8));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("event32_%0d", k), evs_a[k*32 +: 32], satw(m_ev[k], 32));
      chk($sformatf("event8_%0d", k), evs_b[k*8 +: 8], satw(m_ev[k], 8));
    end
  endtask

  task automatic check_zero();
    chk("rst_cyc32", cyc_a, 0); chk("rst_ins32", ins_a, 0); chk("rst_ev32", evs_a[63:0], 0);
    chk("rst_ev32h", evs_a[127:64], 0); chk("rst_ovf32", ovf_a, 0); chk("rst_q32", q_a, 0);
    chk("rst_flags32", {busy_a, valid_a, div0_a, sat_a}, 0);
    chk("rst_cyc8", cyc_b, 0); chk("rst_ins8", ins_b, 0); chk("rst_ev8", evs_b, 0);
    chk("rst_ovf8", ovf_b, 0); chk("rst_q8", q_b, 0);
    chk("rst_flags8", {busy_b, valid_b, div0_b, sat_b}, 0);
  endtask

  task automatic count_run(input int n, input int rmod);
    for (int i = 0; i < n; i++) step(1, 0, rmod > 0 && (i % rmod) == rmod - 1, 4'($urandom), 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 120 && (sbq[0].size() + sbq[1].size()) != 0; i++) step(0, 0, 0, 4'b0, halt);
    chk("result_pending", sbq[0].size() + sbq[1].size(), 0);
    sbq[0].delete();
    sbq[1].delete();
  endtask

  task automatic halt_and_check();
    step(0, 0, 0, 4'b0, 1);
    check_counts();
    wait_drain();
  endtask

  // monitor: pops the scoreboard whenever a result becomes valid
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        bcnt[d] = 0;
        pv[d] = 1'b0;
      end else begin
        if (busy_o[d]) bcnt[d]++;
        if (valid_o[d] && !pv[d]) begin
          if (sbq[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result dut%0d: cpi_valid rose with nothing pending, q=%0h", d, q_o[d]);
          end else begin
            ex = sbq[d].pop_front();
            chk($sformatf("cpi_q dut%0d", d), q_o[d], ex.q);
            chk($sformatf("cpi_div0 dut%0d", d), div0_o[d], ex.div0);
            chk($sformatf("cpi_sat dut%0d", d), sat_o[d], ex.sat);
            chk($sformatf("busy_cycles dut%0d", d), bcnt[d], ex.busy);
          end
          bcnt[d] = 0;
        end else if (valid_o[d] && pv[d]) chk($sformatf("cpi_q_stable dut%0d", d), q_o[d], pq[d]);
        pv[d] = valid_o[d];
        pq[d] = q_o[d];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;
    check_zero();
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 1, 0, 4'b0, 0);
    count_run(100, 2);
    halt_and_check();
    chk("planA_q32", q_a, 32'h200);
    step(0, 0, 0, 4'b0, 0);
    step(0, 1, 0, 4'b0, 0);
    count_run(10, 3);
    halt_and_check();
    chk("planB_q32", q_a, 32'h355);
    chk("planB_sat32", sat_a, 0);
    step(0, 0, 0, 4'b0, 0);
    step(0, 1, 0, 4'b0, 0);
    count_run(20, 0);
    halt_and_check();
    chk("planC_q32", q_a, 32'hFFFF_FFFF);
    chk("planC_div0", div0_a, 1);
    step(0, 0, 0, 4'b0, 0);
    step(0, 1, 0, 4'b0, 0);
    count_run(300, 100);
    halt_and_check();
    chk("planD_cyc8", cyc_b, 8'hFF);
    chk("planD_ovf8", ovf_b[0], 1);
    chk("planD_ins8", ins_b, 3);
    chk("planD_q8", q_b, 8'hFF);
    chk("planD_sat8", sat_b, 1);
    step(0, 0, 0, 4'b0, 0);
    for (int s = 0; s < 6; s++) begin
      int n, rm;
      n = $urandom_range(250, 1);
      rm = $urandom_range(5, 0);
      step(0, 1, 0, 4'b0, 0);
      for (int i = 0; i < n; i++) step($urandom_range(3, 0) != 0, 0, rm != 0 && $urandom_range(rm, 1) == 1, 4'($urandom), 0);
      halt_and_check();
      step(0, 0, 0, 4'b0, 0);
    end
    // reset in the middle of a divide, halt held through release
    step(0, 1, 0, 4'b0, 0);
    count_run(30, 2);
    step(0, 0, 0, 4'b0, 1);
    repeat (5) step(0, 0, 0, 4'b0, 1);
    #2 rst = 1'b1;
    #1 check_zero();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) step(1, 0, 1, 4'($urandom), 1);
    chk("post_rst_busy", {busy_a, busy_b, valid_a, valid_b}, 0);
    check_counts();
    step(0, 0, 0, 4'b0, 0);
    count_run(20, 4);
    halt_and_check();
    step(0, 0, 0, 4'b0, 0);
    // clear coinciding with a halt rise, then a second rise during the divide
    step(0, 1, 0, 4'b0, 0);
    count_run(20, 1);
    step(1, 1, 1, 4'($urandom), 1);
    check_counts();
    chk("clr_halt_flags", {busy_a, busy_b, valid_a, valid_b}, 0);
    repeat (3) step(0, 0, 0, 4'b0, 1);
    chk("clr_halt_idle", {busy_a, busy_b, valid_a, valid_b}, 0);
    step(0, 0, 0, 4'b0, 0);
    count_run(15, 2);
    step(0, 0, 0, 4'b0, 1);
    repeat (4) step(0, 0, 0, 4'b0, 1);
    repeat (2) step(1, 0, 1, 4'($urandom), 0);
    step(0, 0, 0, 4'b0, 1);
    wait_drain();
    chk("rehalt_q32", q_a, 32'h224);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
